btn_debounce_edge: RTL and testbench
====================================

# btn_debounce_edge

Conditions one raw, asynchronous push-button input into a clean, clock-synchronous level plus single-cycle press/release strobes. It sits directly upstream of the team's single-bit registered stages. Its debounced level or press strobe drives their `d` input, so downstream logic only ever sees glitch-free, synchronous transitions. It also keeps a wrapping count of accepted presses for status display.

## Interface
- `STABLE_CYCLES`, default 500000: consecutive cycles the synchronized input must hold a new value before it is accepted (5 ms at 100 MHz). Legal range is 2 to 2^CNT_W − 1.
- `CNT_W`, default 19: width of the stability counter.
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset; clears every register immediately, independent of `clk`.
- `btn_in`  in  1  raw button, asynchronous to `clk`, may bounce.
- `btn_level`  out  1  debounced registered level.
- `btn_press`  out  1  one-cycle strobe on each accepted 0→1 transition.
- `btn_release`  out  1  one-cycle strobe on each accepted 1→0 transition.
- `press_count`  out  8  count of accepted presses, wraps 255→0.

## Operation
- Synchronizer: two flops, `s1 <= btn_in`, `s2 <= s1`. Only `s2` (btn_sync) is used beyond this point.
- Four-state FSM: LOW, ARM_HIGH, HIGH, ARM_LOW. It is reset to LOW.
- LOW: `btn_level`=0. If btn_sync=1, go to ARM_HIGH and set cnt to 0.
- ARM_HIGH: `btn_level`=0.
  - btn_sync=0: return to LOW. Bounce is rejected with no strobe.
  - cnt = STABLE_CYCLES−1: go to HIGH.
  - otherwise: cnt increments.
- HIGH: `btn_level`=1. If btn_sync=0, go to ARM_LOW and set cnt to 0.
- ARM_LOW: mirror of ARM_HIGH.
  - btn_sync=1: return to HIGH, no strobe.
  - cnt = STABLE_CYCLES−1: go to LOW.
- The ARM_HIGH→HIGH transition registers `btn_press`=1 for exactly one cycle and increments `press_count` in the same cycle.
- The ARM_LOW→LOW transition registers `btn_release`=1 for exactly one cycle.
- All outputs are registered. There is no combinational path from `btn_in` to any output.
- `btn_press` and `btn_release` are never high in the same cycle. Each accepted transition produces exactly one strobe.
- cnt is only compared while in an ARM state. It never overflows because the FSM leaves the ARM state at STABLE_CYCLES−1.

## Timing
- Reset values: `btn_level`=0, `btn_press`=0, `btn_release`=0, `press_count`=0, s1=s2=0, cnt=0, state=LOW.
- Define edge e as the first rising edge at which s1 captures the new value. The first edge of the stable window is e+1. Then:
  - `btn_level`, `btn_press` and the new `press_count` appear at edge e+STABLE_CYCLES+2.
  - Release latency is identical.
- Minimum stable pulse: a btn_sync run shorter than STABLE_CYCLES+1 cycles is never accepted.
- Reset mid-ARM: the window is abandoned and no strobe is generated.
- Button held through reset deassertion: a press is detected normally afterwards. `btn_press` fires STABLE_CYCLES+2 edges after the first edge with `rst` low.
- Reset asserted during a strobe cycle: the strobe drops immediately, asynchronously.
- `press_count` wrap: a press at 255 yields 0 together with `btn_press`=1.

## Test plan
- Clean press, STABLE_CYCLES=4: hold btn_in=1 from edge e → `btn_level`=1 and `btn_press`=1 at edge e+6 only. `press_count` becomes 1.
- Bounce rejection, STABLE_CYCLES=4: toggle btn_in 1,0,1,0 every 2 cycles, then hold 1 → no strobe during toggling, one `btn_press` 6 edges after the final rising capture.
- Release after a stable press: drive btn_in to 0 → `btn_release`=1 for one cycle at e+6, `btn_level`=0, `press_count` unchanged.
- Wrap: 256 clean presses → `press_count` reads 255, then 0 on the 256th strobe.
- Async reset mid-ARM: assert `rst` between clock edges at cnt=2 → all outputs 0 before the next edge. After release with btn_in still 1, `btn_press` arrives at edge 6 after `rst` falls.
- Random bounce soak with STABLE_CYCLES=8: compare against a reference model; strobes never overlap and each strobe count matches the accepted transitions.

Source files
------------

// File: rtl/btn_debounce_edge.sv
// btn_debounce_edge: two-flop synchronizer, four-state debounce FSM,
// registered level, press/release strobes and a wrapping press counter.
module btn_debounce_edge #(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic [7:0] press_count
);

  localparam logic [1:0] LOW      = 2'd0;
  localparam logic [1:0] ARM_HIGH = 2'd1;
  localparam logic [1:0] HIGH     = 2'd2;
  localparam logic [1:0] ARM_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic [7:0]       r_count;

  logic w_sync;
  logic w_last;

  assign w_sync = r_s2;
  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= btn_in;
      r_s2 <= r_s1;
    end
  end

  // Strobes default low each cycle; only an accepted ARM exit raises one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= LOW;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_count   <= 8'd0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        LOW: begin
          if (w_sync) begin
            r_state <= ARM_HIGH;
            r_cnt   <= '0;
          end
        end
        ARM_HIGH: begin
          if (!w_sync) begin
            r_state <= LOW;
          end else if (w_last) begin
            r_state <= HIGH;
            r_level <= 1'b1;
            r_press <= 1'b1;
            r_count <= r_count + 8'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!w_sync) begin
            r_state <= ARM_LOW;
            r_cnt   <= '0;
          end
        end
        ARM_LOW: begin
          if (w_sync) begin
            r_state <= HIGH;
          end else if (w_last) begin
            r_state   <= LOW;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= LOW;
      endcase
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign press_count = r_count;

endmodule

// File: tb/tb_btn_debounce_edge.sv
// Self-checking bench: directed cases on a STABLE_CYCLES=4 instance,
// random bounce soak on a STABLE_CYCLES=8 instance, run-length model.
module tb_btn_debounce_edge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       a_lvl, a_prs, a_rel;
  logic       b_lvl, b_prs, b_rel;
  logic [7:0] a_cnt, b_cnt;

  always #5 clk = ~clk;

  btn_debounce_edge #(.STABLE_CYCLES(4), .CNT_W(3)) u_a (
    .clk(clk), .rst(rst), .btn_in(a_in),
    .btn_level(a_lvl), .btn_press(a_prs),
    .btn_release(a_rel), .press_count(a_cnt)
  );

  btn_debounce_edge #(.STABLE_CYCLES(8), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .btn_in(b_in),
    .btn_level(b_lvl), .btn_press(b_prs),
    .btn_release(b_rel), .press_count(b_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Model: a new level is accepted once the synchronized input has
  // differed from the current level for STABLE_CYCLES+1 samples.
  logic [1:0] m_hist [2];
  int         m_run  [2];
  logic       m_lvl  [2];
  logic       m_prs  [2];
  logic       m_rel  [2];
  logic [7:0] m_cnt  [2];
  int         m_np   [2] = '{0, 0};
  int         m_nr   [2] = '{0, 0};
  int         d_np   [2] = '{0, 0};
  int         d_nr   [2] = '{0, 0};

  task automatic model_step(input int i, input int s,
                            input logic din, input logic r);
    logic sync;
    if (r) begin
      m_hist[i] = 2'b00;
      m_run[i]  = 0;
      m_lvl[i]  = 1'b0;
      m_prs[i]  = 1'b0;
      m_rel[i]  = 1'b0;
      m_cnt[i]  = 8'd0;
    end else begin
      sync      = m_hist[i][1];
      m_hist[i] = {m_hist[i][0], din};
      m_prs[i]  = 1'b0;
      m_rel[i]  = 1'b0;
      if (sync != m_lvl[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == s + 1) begin
        m_run[i] = 0;
        m_lvl[i] = sync;
        if (sync) begin
          m_prs[i] = 1'b1;
          m_cnt[i] = m_cnt[i] + 8'd1;
          m_np[i]++;
        end else begin
          m_rel[i] = 1'b1;
          m_nr[i]++;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    model_step(0, 4, a_in, rst);
    model_step(1, 8, b_in, rst);
    chk("A level",   a_lvl, m_lvl[0]);
    chk("A press",   a_prs, m_prs[0]);
    chk("A release", a_rel, m_rel[0]);
    chk("A count",   a_cnt, m_cnt[0]);
    chk("B level",   b_lvl, m_lvl[1]);
    chk("B press",   b_prs, m_prs[1]);
    chk("B release", b_rel, m_rel[1]);
    chk("B count",   b_cnt, m_cnt[1]);
    chk("B overlap", b_prs & b_rel, 1'b0);
    if (b_prs) d_np[1]++;
    if (b_rel) d_nr[1]++;
  end

  task automatic press_rel_a();
    a_in = 1'b1;
    repeat (8) @(negedge clk);
    a_in = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int bp;
    logic v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst level",   a_lvl, 1'b0);
    chk("rst press",   a_prs, 1'b0);
    chk("rst release", a_rel, 1'b0);
    chk("rst count",   a_cnt, 8'd0);
    #2 rst = 1'b0;
    @(negedge clk);

    // clean press: strobe exactly at e+6
    a_in = 1'b1;
    repeat (6) @(negedge clk);
    chk("clean press e+5", a_prs, 1'b0);
    chk("clean level e+5", a_lvl, 1'b0);
    @(negedge clk);
    chk("clean press e+6", a_prs, 1'b1);
    chk("clean level e+6", a_lvl, 1'b1);
    chk("clean count",     a_cnt, 8'd1);
    @(negedge clk);
    chk("clean press e+7", a_prs, 1'b0);
    chk("clean level e+7", a_lvl, 1'b1);

    // release
    a_in = 1'b0;
    repeat (6) @(negedge clk);
    chk("release e+5", a_rel, 1'b0);
    @(negedge clk);
    chk("release e+6", a_rel, 1'b1);
    chk("release lvl", a_lvl, 1'b0);
    chk("release cnt", a_cnt, 8'd1);
    @(negedge clk);
    chk("release e+7", a_rel, 1'b0);

    // bounce rejection
    bp = 0;
    for (int k = 0; k < 4; k++) begin
      a_in = v[k];
      repeat (2) begin
        @(negedge clk);
        if (a_prs) bp++;
      end
    end
    chk("bounce strobes", bp, 0);
    a_in = 1'b1;
    repeat (6) @(negedge clk);
    chk("bounce press e+5", a_prs, 1'b0);
    @(negedge clk);
    chk("bounce press e+6", a_prs, 1'b1);
    chk("bounce count",     a_cnt, 8'd2);
    a_in = 1'b0;
    repeat (8) @(negedge clk);
    chk("bounce released", a_lvl, 1'b0);

    // async reset mid-ARM at cnt=2
    a_in = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midarm rst level",   a_lvl, 1'b0);
    chk("midarm rst press",   a_prs, 1'b0);
    chk("midarm rst release", a_rel, 1'b0);
    chk("midarm rst count",   a_cnt, 8'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("held press f+5", a_prs, 1'b0);
    @(negedge clk);
    chk("held press f+6", a_prs, 1'b1);
    chk("held level",     a_lvl, 1'b1);
    chk("held count",     a_cnt, 8'd1);

    // reset during the strobe cycle
    #2 rst = 1'b1;
    #1;
    chk("strobe rst press", a_prs, 1'b0);
    chk("strobe rst level", a_lvl, 1'b0);
    chk("strobe rst count", a_cnt, 8'd0);
    a_in = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // counter wrap
    for (int k = 0; k < 255; k++) press_rel_a();
    chk("wrap 255", a_cnt, 8'd255);
    a_in = 1'b1;
    repeat (7) @(negedge clk);
    chk("wrap press", a_prs, 1'b1);
    chk("wrap zero",  a_cnt, 8'd0);
    a_in = 1'b0;
    repeat (8) @(negedge clk);

    // random bounce soak on instance B
    repeat (300) begin
      b_in = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 14)) @(negedge clk);
    end
    b_in = 1'b0;
    repeat (20) @(negedge clk);
    chk("B press tally",   d_np[1], m_np[1]);
    chk("B release tally", d_nr[1], m_nr[1]);
    chk("B balance",       d_np[1] - d_nr[1], b_lvl);
    chk("B saw presses",   32'(d_np[1] > 0), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
